// File: rtl/hex_led_io_port_pkg.sv
// Shared constants and types for the hex/LED output port: register offsets,
// CTRL bit positions and the all-segments-off pattern.
package hex_led_io_port_pkg;

    localparam int NUM_HEX  = 6;

    localparam int HEX0_OFS = 0;
    localparam int HEX1_OFS = 1;
    localparam int HEX2_OFS = 2;
    localparam int HEX3_OFS = 3;
    localparam int HEX4_OFS = 4;
    localparam int HEX5_OFS = 5;
    localparam int LEDR_OFS = 6;
    localparam int CTRL_OFS = 7;

    localparam int HEX_OFS [NUM_HEX] = '{HEX0_OFS, HEX1_OFS, HEX2_OFS,
                                         HEX3_OFS, HEX4_OFS, HEX5_OFS};

    localparam int CTRL_DEC   = 0;
    localparam int CTRL_BLANK = 1;
    localparam int CTRL_BLINK = 2;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Field order matches the CTRL bit indices so the struct reads back as-is.
    typedef struct packed {
        logic blink;
        logic blank;
        logic dec;
    } ctrl_t;

endpackage

// File: rtl/hex_led_io_port_if.sv
// Processor-side bus of the hex/LED port: select, direction, offset, write
// data, registered read data and its one-cycle valid pulse.
interface hex_led_io_port_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
) ();

    logic              Sel;
    logic              W;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] DOUT;
    logic [DATA_W-1:0] DIN;
    logic              RdValid;

    modport master (output Sel, W, Addr, DOUT, input DIN, RdValid);
    modport slave  (input Sel, W, Addr, DOUT, output DIN, RdValid);

endinterface

// File: rtl/hex_led_io_port_seg7_decode.sv
// Combinational hex digit to active-low 7-segment decoder (bit0 = a .. bit6 = g).
module seg7_decode (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    end

endmodule

// File: rtl/hex_led_io_port.sv
// Memory-mapped display/LED responder: six HEX pattern registers, LEDR and CTRL
// with read-back. Define HEX_BLINK_EN to add the CTRL.BLINK display blinker.
module hex_led_io_port
    import hex_led_io_port_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 3,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                     Clock,
    input  logic                     Resetn,
    hex_led_io_port_if.slave         bus,
    output logic [6:0]               HEX0,
    output logic [6:0]               HEX1,
    output logic [6:0]               HEX2,
    output logic [6:0]               HEX3,
    output logic [6:0]               HEX4,
    output logic [6:0]               HEX5,
    output logic [9:0]               LEDR
);

    logic [6:0]        hex_pat [NUM_HEX];
    logic [9:0]        led_r;
    ctrl_t             ctrl;
    logic [6:0]        hex_q   [NUM_HEX];
    logic [9:0]        led_q;
    logic [6:0]        dec_seg;
    logic [6:0]        wr_pat;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic              rd_en;
    logic              ctrl_wr;
    logic              hex_off;

    assign wr_en   = bus.Sel & bus.W;
    assign rd_en   = bus.Sel & ~bus.W;
    assign ctrl_wr = wr_en && (bus.Addr == ADDR_W'(CTRL_OFS));

    seg7_decode u_seg7_decode (
        .nib (bus.DOUT[3:0]),
        .seg (dec_seg)
    );

    // Stored patterns are active-low; raw writes are inverted so a processor 1 lights a segment.
    assign wr_pat = ctrl.dec ? dec_seg : ~bus.DOUT[6:0];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            // NOTE: the pattern array is a handful of flops whose reset value drives the pins, so every entry is reset.
            for (int i = 0; i < NUM_HEX; i++) hex_pat[i] <= SEG_OFF;
            led_r <= '0;
            ctrl  <= '0;
        end else if (wr_en) begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values, independent of statement order.
            for (int i = 0; i < NUM_HEX; i++) begin
                if (bus.Addr == ADDR_W'(HEX_OFS[i])) hex_pat[i] <= wr_pat;
            end
            if (bus.Addr == ADDR_W'(LEDR_OFS)) led_r <= bus.DOUT[9:0];
            if (ctrl_wr) begin
                ctrl.dec   <= bus.DOUT[CTRL_DEC];
                ctrl.blank <= bus.DOUT[CTRL_BLANK];
`ifdef HEX_BLINK_EN
                ctrl.blink <= bus.DOUT[CTRL_BLINK];
`else
                ctrl.blink <= 1'b0;
`endif
            end
        end
    end

    always_comb begin
        // NOTE: defaulting the output before the address compares keeps the decode from inferring latches.
        rd_data = '0;
        for (int i = 0; i < NUM_HEX; i++) begin
            if (bus.Addr == ADDR_W'(HEX_OFS[i])) rd_data[6:0] = ~hex_pat[i];
        end
        if (bus.Addr == ADDR_W'(LEDR_OFS)) rd_data[9:0] = led_r;
        if (bus.Addr == ADDR_W'(CTRL_OFS)) rd_data[2:0] = ctrl;
    end

    // DIN only moves on a read so the processor may sample it late.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            bus.DIN     <= '0;
            bus.RdValid <= 1'b0;
        end else begin
            bus.RdValid <= rd_en;
            if (rd_en) bus.DIN <= rd_data;
        end
    end

`ifdef HEX_BLINK_EN
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [CNT_W-1:0] blink_cnt;
    logic             blink_off;

    // A CTRL write with BLINK clear restarts the cadence in the visible phase.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (ctrl_wr && !bus.DOUT[CTRL_BLINK]) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            blink_cnt <= '0;
            blink_off <= ~blink_off;
        end else begin
            blink_cnt <= blink_cnt + CNT_W'(1);
        end
    end

    assign hex_off = ctrl.blank | (ctrl.blink & blink_off);
`else
    logic unused_blink_div;
    assign unused_blink_div = (BLINK_DIV > 0);
    assign hex_off          = ctrl.blank;
`endif

    generate
        if (DATA_W > 10) begin : g_unused_dout
            logic unused_dout_hi;
            assign unused_dout_hi = ^bus.DOUT[DATA_W-1:10];
        end
    endgenerate

    // Registered pin drive so blanking and register updates never glitch the displays.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= SEG_OFF;
            led_q <= '0;
        end else begin
            for (int i = 0; i < NUM_HEX; i++) hex_q[i] <= hex_off ? SEG_OFF : hex_pat[i];
            led_q <= led_r;
        end
    end

    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
    assign LEDR = led_q;

endmodule

// File: tb/tb_hex_led_io_port.sv
// Scoreboard bench for hex_led_io_port: the driver pushes expected read data and
// expected pin states from a processor-view model; a negedge monitor compares.
module tb_hex_led_io_port;
    import hex_led_io_port_pkg::*;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 3;
    localparam int BLINK_DIV = 4;

    // Lit segments (1 = on), bit0 = a .. bit6 = g, for hex digits 0..F.
    localparam logic [6:0] LIT_TBL [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int          due;
        logic [15:0] data;
    } rd_exp_t;

    typedef struct {
        int          due;
        logic [41:0] hex;
        logic [9:0]  led;
    } out_exp_t;

    logic       Clock = 1'b0;
    logic       Resetn;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;

    rd_exp_t  rd_q [$];
    out_exp_t out_q [$];
    rd_exp_t  mon_re;
    out_exp_t mon_oe;
    logic [15:0] last_din;

    // Processor-view model: lit segments per display, LED word, CTRL flags,
    // and the number of clock edges since the blink cadence last restarted.
    logic [6:0] m_lit [6];
    logic [9:0] m_led;
    logic       m_dec, m_blank, m_blink;
    int         m_t;

    hex_led_io_port_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    hex_led_io_port #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BLINK_DIV (BLINK_DIV)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus),
        .HEX0   (HEX0),
        .HEX1   (HEX1),
        .HEX2   (HEX2),
        .HEX3   (HEX3),
        .HEX4   (HEX4),
        .HEX5   (HEX5),
        .LEDR   (LEDR)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) m_lit[i] = '0;
        m_led   = '0;
        m_dec   = 1'b0;
        m_blank = 1'b0;
        m_blink = 1'b0;
        m_t     = 0;
    endfunction

    function automatic logic [41:0] exp_hex();
        logic [41:0] h;
        logic        off;
        off = m_blank || (m_blink && (((m_t / BLINK_DIV) % 2) == 1));
        for (int i = 0; i < 6; i++) h[i*7 +: 7] = off ? 7'h7F : ~m_lit[i];
        return h;
    endfunction

    function automatic logic [15:0] model_read(input logic [2:0] a);
        if (a < 3'd6)       return {9'b0, m_lit[a]};
        else if (a == 3'd6) return {6'b0, m_led};
        else                return {13'b0, m_blink, m_blank, m_dec};
    endfunction

    function automatic void model_step(input logic sel, input logic w,
                                       input logic [2:0] a, input logic [15:0] d);
        logic restart;
        restart = sel && w && (a == 3'd7) && !d[2];
        if (sel && w) begin
            if (a < 3'd6)       m_lit[a] = m_dec ? LIT_TBL[d[3:0]] : d[6:0];
            else if (a == 3'd6) m_led = d[9:0];
            else begin
                m_dec   = d[0];
                m_blank = d[1];
`ifdef HEX_BLINK_EN
                m_blink = d[2];
`else
                m_blink = 1'b0;
`endif
            end
        end
        m_t = restart ? 0 : m_t + 1;
    endfunction

    // Called one time unit after a rising edge; the access lands on the next edge.
    task automatic drive(input logic sel, input logic w, input logic [2:0] a, input logic [15:0] d);
        out_exp_t oe;
        rd_exp_t  re;
        oe.due = cyc + 1;
        oe.hex = exp_hex();
        oe.led = m_led;
        out_q.push_back(oe);
        if (sel && !w) begin
            re.due  = cyc + 1;
            re.data = model_read(a);
            rd_q.push_back(re);
        end
        model_step(sel, w, a, d);
        bus.Sel  = sel;
        bus.W    = w;
        bus.Addr = a;
        bus.DOUT = d;
        @(posedge Clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        drive(1'b1, 1'b1, a, d);
    endtask

    task automatic rd(input logic [2:0] a);
        drive(1'b1, 1'b0, a, 16'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 3'd0, 16'h0);
    endtask

    always @(negedge Clock) begin
        if (!Resetn) begin
            rd_q.delete();
            out_q.delete();
            last_din = '0;
        end else begin
            if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
                mon_re = rd_q.pop_front();
                check("rd_valid", bus.RdValid, 1);
                check("rd_data", bus.DIN, mon_re.data);
                last_din = mon_re.data;
            end else begin
                check("rd_idle", bus.RdValid, 0);
                check("din_hold", bus.DIN, last_din);
            end
            if (out_q.size() > 0 && out_q[0].due == cyc) begin
                mon_oe = out_q.pop_front();
                check("hex_out", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, mon_oe.hex);
                check("ledr_out", LEDR, mon_oe.led);
            end
        end
    end

    initial begin
        logic sel, w;
        logic [2:0]  a;
        logic [15:0] d;

        bus.Sel  = 1'b0;
        bus.W    = 1'b0;
        bus.Addr = '0;
        bus.DOUT = '0;
        Resetn   = 1'b1;
        model_reset();

        #2 Resetn = 1'b0;
        #1;
        check("rst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h7F}});
        check("rst_ledr", LEDR, 10'h0);
        check("rst_din", bus.DIN, 16'h0);
        check("rst_rdvalid", bus.RdValid, 0);
        repeat (2) @(posedge Clock);
        #1 Resetn = 1'b1;

        // Hex-decode write of digit 3, then read-back in processor polarity.
        wr(3'd7, 16'h0001);
        wr(3'd0, 16'h0003);
        idle(2);
        check("hex0_dec3", HEX0, 7'b0110000);
        rd(3'd0);
        idle(2);

        // Raw pattern and LED writes; upper data bits ignored.
        wr(3'd7, 16'h0000);
        wr(3'd5, 16'h0049);
        wr(3'd6, 16'hFFFF);
        idle(2);
        check("hex5_raw", HEX5, 7'b0110110);
        check("ledr_all", LEDR, 10'h3FF);
        rd(3'd6);
        rd(3'd5);
        rd(3'd7);

        // Blank hides every display and leaves patterns and LEDs intact.
        wr(3'd7, 16'h0002);
        idle(2);
        check("blank_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h7F}});
        check("blank_ledr", LEDR, 10'h3FF);
        wr(3'd7, 16'h0000);
        idle(2);
        check("unblank_hex0", HEX0, 7'b0110000);
        check("unblank_hex5", HEX5, 7'b0110110);

        // Write then read on consecutive cycles, then a reset during a read.
        wr(3'd6, 16'h0155);
        rd(3'd6);
        idle(2);
        bus.Sel  = 1'b1;
        bus.W    = 1'b0;
        bus.Addr = 3'd6;
        #3 Resetn = 1'b0;
        model_reset();
        #1;
        check("midrst_rdvalid", bus.RdValid, 0);
        check("midrst_ledr", LEDR, 10'h0);
        check("midrst_din", bus.DIN, 16'h0);
        check("midrst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h7F}});
        @(posedge Clock);
        #1;
        check("midrst_edge_rdvalid", bus.RdValid, 0);
        bus.Sel = 1'b0;
        #1 Resetn = 1'b1;
        idle(2);
        rd(3'd6);

`ifdef HEX_BLINK_EN
        wr(3'd7, 16'h0000);
        wr(3'd0, 16'h0008);
        wr(3'd7, 16'h0004);
        idle(20);
        rd(3'd7);
        wr(3'd7, 16'h0000);
        idle(6);
`endif

        for (int n = 0; n < 400; n++) begin
            sel = ($urandom_range(0, 3) != 0);
            w   = $urandom_range(0, 1) == 1;
            a   = 3'($urandom_range(0, 7));
            d   = 16'($urandom);
            if (a == 3'd7) d[1] = ($urandom_range(0, 3) == 0);
            drive(sel, w, a, d);
        end

        idle(3);
        @(negedge Clock);
        #1;
        check("drain", rd_q.size() + out_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
